// File: rtl/avl_ram_slave.sv
// Avalon-MM RAM slave: 2^ADDR_WIDTH x 32 words, byte enables, WAIT_STATES stall cycles per access.
// Define AVL_RAM_SLAVE_RW_ERR_EN to drop simultaneous read+write requests and flag them on rw_err.
module avl_ram_slave #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rest,
  input  logic [31:0] avl_s0_address,
  input  logic        avl_s0_read,
  input  logic        avl_s0_write,
  input  logic [31:0] avl_s0_writedata,
  input  logic [3:0]  avl_s0_byteenable,
  output logic [31:0] avl_s0_readdata,
  output logic        avl_s0_waitrequest,
  output logic        avl_s0_readdatavalid,
  output logic        rw_err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] ACCEPT = 2'd2;

  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  req;
  logic                  accept;
  logic                  do_write;
  logic                  do_read;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  unused_addr;
  logic [31:0]           mem [DEPTH];

  assign req         = avl_s0_read | avl_s0_write;
  assign word_addr   = avl_s0_address[ADDR_WIDTH+1:2];
  assign unused_addr = ^{avl_s0_address[31:ADDR_WIDTH+2], avl_s0_address[1:0]};

  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    avl_s0_waitrequest = 1'b1;
    if (!rest) begin
      case (state_q)
        IDLE: begin
          if (WAIT_STATES == 0) begin
            avl_s0_waitrequest = 1'b0;
          end else if (req) begin
            cnt_d   = WAIT_LOAD;
            // The IDLE cycle is itself the first stall, so a single wait state skips WAIT.
            state_d = (WAIT_LOAD == 4'd0) ? ACCEPT : WAIT;
          end
        end
        WAIT: begin
          if (!req) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = ACCEPT;
          end
        end
        ACCEPT: begin
          avl_s0_waitrequest = 1'b0;
          state_d            = IDLE;
          cnt_d              = 4'd0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  assign accept = req & ~avl_s0_waitrequest;

`ifdef AVL_RAM_SLAVE_RW_ERR_EN
  assign do_write = accept & avl_s0_write & ~avl_s0_read;
  assign do_read  = accept & avl_s0_read & ~avl_s0_write;

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      rw_err <= 1'b0;
    end else if (accept && avl_s0_read && avl_s0_write) begin
      rw_err <= 1'b1;
    end
  end
`else
  // A colliding request is treated as a write.
  assign do_write = accept & avl_s0_write;
  assign do_read  = accept & avl_s0_read & ~avl_s0_write;
  assign rw_err   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state_q              <= IDLE;
      cnt_q                <= 4'd0;
      avl_s0_readdatavalid <= 1'b0;
      avl_s0_readdata      <= 32'd0;
    end else begin
      state_q              <= state_d;
      cnt_q                <= cnt_d;
      avl_s0_readdatavalid <= do_read;
      if (do_read) avl_s0_readdata <= mem[word_addr];
    end
  end

  // Memory has no reset so its contents survive rest.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (avl_s0_byteenable[i]) mem[word_addr][8*i +: 8] <= avl_s0_writedata[8*i +: 8];
      end
    end
  end

endmodule
